// File: rtl/instruction_issue.sv
// Single-entry issue stage: holds one decoded instruction, checks RAW/WAW hazards
// against a register scoreboard and dispatches it to one execution pipe.
module instruction_issue #(
    parameter int  NUM_REGS   = 32,
    parameter int  NUM_PIPES  = 4,
    parameter int  CTRL_WIDTH = 8,
    localparam int REG_WIDTH  = $clog2(NUM_REGS),
    localparam int INF_WIDTH  = 3 * REG_WIDTH + 1 + NUM_PIPES + CTRL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_do_branch,
    input  logic                 id_valid,
    input  logic [INF_WIDTH-1:0] id_ix_inf,
    output logic                 ix_ready,
    input  logic                 wb_valid,
    input  logic [REG_WIDTH-1:0] wb_rd,
    input  logic [NUM_PIPES-1:0] pipe_ready,
    output logic [NUM_PIPES-1:0] ix_valid,
    output logic [INF_WIDTH-1:0] ix_inf
);

    // exe_pipe bit order: 0 ALU, 1 MUL, 2 DIV, 3 LSU.
    typedef struct packed {
        logic [REG_WIDTH-1:0]  a1;
        logic [REG_WIDTH-1:0]  a2;
        logic [REG_WIDTH-1:0]  rd;
        logic                  register_write;
        logic [NUM_PIPES-1:0]  exe_pipe;
        logic [CTRL_WIDTH-1:0] controls;
    } id_ix_inf_t;

    id_ix_inf_t           hold_inf_reg;
    id_ix_inf_t           ix_inf_reg;
    logic                 hold_valid_reg;
    logic [NUM_PIPES-1:0] ix_valid_reg;
    logic [NUM_REGS-1:0]  scoreboard_reg;
    logic [NUM_REGS-1:0]  scoreboard_next;
    logic [NUM_REGS-1:0]  pending;
    logic [NUM_PIPES-1:0] pipe_avail;
    logic [NUM_PIPES-1:0] pipe_grant;
    logic                 hazard;
    logic                 pipe_ok;
    logic                 issue_fire;
    logic                 issue_set;

    // A same-cycle writeback removes the hazard before it is evaluated.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign pending[gi]         = 1'b0;
                assign scoreboard_next[gi] = 1'b0;
            end else begin : g_bit
                assign pending[gi] = scoreboard_reg[gi]
                                   & ~(wb_valid && (wb_rd == REG_WIDTH'(gi)));
                assign scoreboard_next[gi] = pending[gi]
                                   | (issue_set && (hold_inf_reg.rd == REG_WIDTH'(gi)));
            end
        end
    endgenerate

    assign hazard = pending[hold_inf_reg.a1]
                  | pending[hold_inf_reg.a2]
                  | (hold_inf_reg.register_write & pending[hold_inf_reg.rd]);

    // Lowest ready pipe wins, so a malformed multi-bit exe_pipe still strobes one pipe.
    assign pipe_avail = hold_inf_reg.exe_pipe & pipe_ready;
    assign pipe_grant = pipe_avail & (~pipe_avail + NUM_PIPES'(1));
    assign pipe_ok    = (hold_inf_reg.exe_pipe == '0) | (|pipe_avail);

    assign issue_fire = hold_valid_reg & ~hazard & pipe_ok & ~wb_do_branch;
    assign issue_set  = issue_fire & hold_inf_reg.register_write
                      & (hold_inf_reg.rd != '0) & (hold_inf_reg.exe_pipe != '0);
    assign ix_ready   = ~hold_valid_reg | issue_fire | wb_do_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            ix_valid_reg   <= '0;
            scoreboard_reg <= '0;
        end else if (wb_do_branch) begin
            hold_valid_reg <= 1'b0;
            ix_valid_reg   <= '0;
            scoreboard_reg <= '0;
        end else begin
            if (id_valid && ix_ready) begin
                hold_valid_reg <= 1'b1;
            end else if (issue_fire) begin
                hold_valid_reg <= 1'b0;
            end
            ix_valid_reg   <= issue_fire ? pipe_grant : '0;
            scoreboard_reg <= scoreboard_next;
        end
    end

    // Payload registers carry no reset; their contents only matter alongside a valid.
    always_ff @(posedge clk) begin
        if (!wb_do_branch && id_valid && ix_ready) begin
            hold_inf_reg <= id_ix_inf;
        end
        if (issue_fire) begin
            ix_inf_reg <= hold_inf_reg;
        end
    end

    assign ix_valid = ix_valid_reg;
    assign ix_inf   = ix_inf_reg;

endmodule

// File: tb/tb_instruction_issue.sv
// Directed vector bench for instruction_issue: a table of per-cycle stimulus with
// expected ix_ready / ix_valid / ix_inf, plus a reset-override sequence.
module tb_instruction_issue;

    localparam int W = 28;
    localparam logic [3:0] A = 4'b0001;
    localparam logic [3:0] M = 4'b0010;
    localparam logic [3:0] D = 4'b0100;
    localparam logic [3:0] L = 4'b1000;
    localparam logic [3:0] F = 4'b1111;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_do_branch;
    logic         id_valid;
    logic [W-1:0] id_ix_inf;
    logic         ix_ready;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [3:0]   pipe_ready;
    logic [3:0]   ix_valid;
    logic [W-1:0] ix_inf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_issue dut (
        .clk          (clk),
        .rst          (rst),
        .wb_do_branch (wb_do_branch),
        .id_valid     (id_valid),
        .id_ix_inf    (id_ix_inf),
        .ix_ready     (ix_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .pipe_ready   (pipe_ready),
        .ix_valid     (ix_valid),
        .ix_inf       (ix_inf)
    );

    typedef struct {
        logic         idv;
        logic [W-1:0] inf;
        logic         wbv;
        logic [4:0]   wbrd;
        logic [3:0]   pr;
        logic         br;
        logic         exp_ready;
        logic [3:0]   exp_ixv;
        logic [W-1:0] exp_inf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [W-1:0] mk(input logic [4:0] a1, input logic [4:0] a2,
                                        input logic [4:0] rd, input logic rw,
                                        input logic [3:0] pipe, input logic [7:0] ctrl);
        return {a1, a2, rd, rw, pipe, ctrl};
    endfunction

    task automatic add(input logic idv, input logic [W-1:0] inf, input logic wbv,
                       input logic [4:0] wbrd, input logic [3:0] pr, input logic br,
                       input logic er, input logic [3:0] ev, input logic [W-1:0] ei);
        vec_t v;
        v.idv = idv; v.inf = inf; v.wbv = wbv; v.wbrd = wbrd; v.pr = pr; v.br = br;
        v.exp_ready = er; v.exp_ixv = ev; v.exp_inf = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [W-1:0] add1, add2, mul5, add6, add9, ld10, add11, addi0, fence, add13;
        logic [W-1:0] add3, add4, add4b, div7, add8, add15, add16, add17, add20, add21;
        logic [W-1:0] z;

        z     = '0;
        add1  = mk(0, 0, 1, 1, A, 8'h01);
        add2  = mk(0, 0, 2, 1, A, 8'h02);
        mul5  = mk(0, 0, 5, 1, M, 8'h05);
        add6  = mk(5, 0, 6, 1, A, 8'h06);
        add9  = mk(0, 0, 9, 1, A, 8'h09);
        ld10  = mk(0, 0, 10, 1, L, 8'h0a);
        add11 = mk(0, 0, 11, 1, A, 8'h0b);
        addi0 = mk(0, 0, 0, 1, A, 8'h20);
        fence = mk(0, 0, 0, 0, 4'b0000, 8'h30);
        add13 = mk(0, 0, 13, 1, A, 8'h0d);
        add3  = mk(0, 0, 3, 1, A, 8'h03);
        add4  = mk(3, 0, 4, 1, A, 8'h04);
        add4b = mk(0, 0, 4, 1, A, 8'h44);
        div7  = mk(0, 0, 7, 1, D, 8'h07);
        add8  = mk(7, 0, 8, 1, A, 8'h08);
        add15 = mk(0, 0, 15, 1, A, 8'h0f);
        add16 = mk(7, 6, 16, 1, A, 8'h10);
        add17 = mk(0, 0, 17, 1, A, 8'h11);
        add20 = mk(0, 0, 20, 1, A, 8'h14);
        add21 = mk(0, 0, 21, 1, A, 8'h15);

        //  idv inf    wbv wbrd pr       br rdy ixv inf
        add(0, z,     0, 0, F,       0, 1, 0, z);      // 0 idle
        add(1, add1,  0, 0, F,       0, 1, 0, z);      // 1 accept ADD x1
        add(1, add2,  0, 0, F,       0, 1, A, add1);   // 2 back-to-back
        add(0, z,     0, 0, F,       0, 1, A, add2);   // 3
        add(1, mul5,  0, 0, F,       0, 1, 0, z);      // 4 MUL x5
        add(1, add6,  0, 0, F,       0, 1, M, mul5);   // 5 ADD x6,x5 held
        add(1, add9,  0, 0, F,       0, 0, 0, z);      // 6 RAW stall
        add(1, add9,  0, 0, F,       0, 0, 0, z);      // 7
        add(1, add9,  1, 5, F,       0, 1, A, add6);   // 8 writeback bypass
        add(0, z,     0, 0, F,       0, 1, A, add9);   // 9
        add(1, ld10,  0, 0, 4'b0111, 0, 1, 0, z);      // 10 LSU load
        add(1, add11, 0, 0, 4'b0111, 0, 0, 0, z);      // 11 LSU busy
        add(1, add11, 0, 0, 4'b0111, 0, 0, 0, z);      // 12
        add(1, add11, 0, 0, 4'b0111, 0, 0, 0, z);      // 13
        add(1, add11, 0, 0, F,       0, 1, L, ld10);   // 14 LSU ready
        add(0, z,     0, 0, F,       0, 1, A, add11);  // 15
        add(1, addi0, 0, 0, F,       0, 1, 0, z);      // 16 ADDI x0
        add(1, fence, 0, 0, F,       0, 1, A, addi0);  // 17 FENCE held
        add(1, add13, 0, 0, F,       0, 1, 0, z);      // 18 FENCE drains silently
        add(0, z,     0, 0, F,       0, 1, A, add13);  // 19
        add(1, add3,  0, 0, F,       0, 1, 0, z);      // 20 ADD x3
        add(0, z,     1, 3, F,       0, 1, A, add3);   // 21 collision set/clear x3
        add(1, add4,  0, 0, F,       0, 1, 0, z);      // 22 ADD x4,x3
        add(0, z,     0, 0, F,       0, 0, 0, z);      // 23 x3 still pending
        add(0, z,     1, 3, F,       0, 1, A, add4);   // 24
        add(1, add4b, 0, 0, F,       0, 1, 0, z);      // 25 WAW on x4
        add(0, z,     0, 0, F,       0, 0, 0, z);      // 26
        add(0, z,     1, 4, F,       0, 1, A, add4b);  // 27
        add(1, div7,  0, 0, F,       0, 1, 0, z);      // 28 DIV x7
        add(1, add8,  0, 0, F,       0, 1, D, div7);   // 29 ADD x8,x7 held
        add(0, z,     0, 0, F,       0, 0, 0, z);      // 30 RAW stall
        add(1, add15, 0, 0, F,       1, 1, 0, z);      // 31 flush, id ignored
        add(0, z,     0, 0, F,       0, 1, 0, z);      // 32 nothing held
        add(1, add16, 0, 0, F,       0, 1, 0, z);      // 33 reads x7,x6
        add(0, z,     0, 0, F,       0, 1, A, add16);  // 34 scoreboard was cleared
        add(1, add17, 0, 0, F,       0, 1, 0, z);      // 35
        add(0, z,     0, 0, F,       1, 1, 0, z);      // 36 flush blocks issue
        add(0, z,     0, 0, F,       0, 1, 0, z);      // 37 held op gone

        rst = 1'b1; wb_do_branch = 1'b0; id_valid = 1'b0; id_ix_inf = '0;
        wb_valid = 1'b0; wb_rd = '0; pipe_ready = F;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset ix_ready", W'(ix_ready), W'(1));
        check("reset ix_valid", W'(ix_valid), W'(0));
        @(posedge clk); #1;
        check("post-reset ix_valid", W'(ix_valid), W'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            id_valid     = vecs[i].idv;
            id_ix_inf    = vecs[i].inf;
            wb_valid     = vecs[i].wbv;
            wb_rd        = vecs[i].wbrd;
            pipe_ready   = vecs[i].pr;
            wb_do_branch = vecs[i].br;
            @(negedge clk);
            check($sformatf("v%0d ix_ready", i), W'(ix_ready), W'(vecs[i].exp_ready));
            @(posedge clk); #1;
            check($sformatf("v%0d ix_valid", i), W'(ix_valid), W'(vecs[i].exp_ixv));
            check($sformatf("v%0d onehot", i), W'($onehot0(ix_valid)), W'(1));
            if (vecs[i].exp_ixv != 4'b0000)
                check($sformatf("v%0d ix_inf", i), ix_inf, vecs[i].exp_inf);
            $display("vec %0d: ix_ready=%b ix_valid=%b ix_inf=%h", i, ix_ready, ix_valid, ix_inf);
        end

        // Reset wins over a ready-to-fire held op and concurrent id/wb activity.
        id_valid = 1'b1; id_ix_inf = add20; wb_valid = 1'b0; wb_do_branch = 1'b0; pipe_ready = F;
        @(posedge clk); #1;
        rst = 1'b1; id_ix_inf = add21; wb_valid = 1'b1; wb_rd = 5'd1; wb_do_branch = 1'b1;
        @(posedge clk); #1;
        check("rst blocks issue", W'(ix_valid), W'(0));
        $display("rst cycle: ix_valid=%b", ix_valid);
        rst = 1'b0; id_valid = 1'b0; wb_valid = 1'b0; wb_do_branch = 1'b0;
        @(negedge clk);
        check("after rst ix_ready", W'(ix_ready), W'(1));
        @(posedge clk); #1;
        check("after rst ix_valid", W'(ix_valid), W'(0));
        $display("after rst: ix_ready=%b ix_valid=%b", ix_ready, ix_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_issue.md
INSTRUCTION_ISSUE -- requirements
Module: instruction_issue

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, giving the architectural register count tracked by the scoreboard.
REQ-002 SHALL have parameter NUM_PIPES, default 4, giving the execution pipe count (ALU, MUL, DIV, LSU, indexed by EXE_PIPE_ID_*).
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports clk and rst.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wb_do_branch  input  1  branch redirect from WB; flushes this stage.
REQ-007 id_valid  input  1  ID holds a valid decoded instruction.
REQ-008 id_ix_inf  input  id_ix_inf_t  decoded instruction (a1, a2, rd, register_write, exe_pipe, controls).
REQ-009 ix_ready  output  1  stage can accept id_ix_inf this cycle; drives the upstream stall.
REQ-010 wb_valid  input  1  a register write retires this cycle.
REQ-011 wb_rd  input  REG_WIDTH  destination of the retiring write.
REQ-012 pipe_ready  input  NUM_PIPES  per-pipe "can accept" signal.
REQ-013 ix_valid  output  NUM_PIPES  registered one-hot dispatch strobe.
REQ-014 ix_inf  output  id_ix_inf_t  registered copy of the dispatched instruction.

Function
REQ-015 SHALL hold one instruction in a holding register (hold_valid, hold_inf).
REQ-016 SHALL drive ix_ready = !hold_valid | issue_fire, combinationally.
REQ-017 SHALL load the holding register on an edge where id_valid & ix_ready; otherwise a firing issue clears hold_valid.
REQ-018 SHALL keep a NUM_REGS-bit scoreboard; bit 0 is constant 0.
REQ-019 SHALL compute pending = scoreboard & ~(wb_valid ? onehot(wb_rd) : 0), so a same-cycle writeback clears the hazard.
REQ-020 SHALL flag a hazard when pending[a1], pending[a2] (RAW) or, if register_write, pending[rd] (WAW) is set; index 0 never hazards.
REQ-021 SHALL compute issue_fire = hold_valid & !hazard & |(hold_inf.exe_pipe & pipe_ready) & !wb_do_branch.
REQ-022 SHALL retire a held instruction whose exe_pipe == 0 in one cycle without asserting any ix_valid bit or touching the scoreboard.
REQ-023 SHALL on issue_fire register ix_valid <= hold_inf.exe_pipe and ix_inf <= hold_inf; otherwise ix_valid <= 0 and ix_inf holds its value.
REQ-024 SHALL set scoreboard[rd] on issue_fire when register_write & rd != 0.
REQ-025 SHALL clear scoreboard[wb_rd] on wb_valid; a same-cycle set of the same index by issue wins.
REQ-026 SHALL give minimum latency: accept on edge E0, ix_valid high for exactly one cycle after edge E1.
REQ-027 SHALL give sustained throughput of one instruction per cycle while there are no hazards and pipe_ready is asserted.
REQ-028 SHALL never assert more than one ix_valid bit in a cycle.
REQ-029 SHALL on wb_do_branch clear hold_valid, ix_valid and the entire scoreboard at the next edge, ignore id_valid that cycle, and drive ix_ready = 1; all in-flight younger work is squashed by the pipes.
REQ-030 SHALL keep hold_inf stable while hold_valid & !issue_fire, regardless of id_ix_inf.

Reset
REQ-031 SHALL on rst clear hold_valid, ix_valid = 0 and scoreboard = 0; ix_inf and hold_inf data are don't-care.
REQ-032 SHALL let rst override wb_do_branch, wb_valid and id_valid in the same cycle.
REQ-033 SHALL drive ix_ready = 1 on the first cycle after rst deasserts.

Verification
REQ-034 Back-to-back independent ops: ADD x1 then ADD x2 (ALU, pipe_ready=4'b1111) -> ix_valid=0001 on consecutive cycles, ix_ready stays 1.
REQ-035 RAW hazard: MUL x5 issued, then ADD x6,x5,x0 -> ADD held, ix_ready=0 until wb_valid with wb_rd=5; ADD issues the edge after that writeback, with same-cycle bypass.
REQ-036 Backpressure: LSU load with pipe_ready[LSU]=0 for 3 cycles -> no ix_valid, hold_inf unchanged; ix_valid=1000 one edge after pipe_ready rises.
REQ-037 Flush: DIV x7 pending and an instruction held, then wb_do_branch=1 -> next cycle hold_valid=0, scoreboard=0, ix_valid=0, ix_ready=1.
REQ-038 Writes to x0 and exe_pipe=0: ADDI x0,... issues without setting the scoreboard; FENCE (non-.i) drains with no ix_valid bit.
REQ-039 Collision: issue of rd=3 on the same edge as wb_valid with wb_rd=3 -> scoreboard[3]=1 afterwards.
